// File: rtl/pe_ctrl_pkg.sv
// Shared types and defaults for the PE array sequencer.
package pe_ctrl_pkg;
  localparam int DEF_PIPE_LAT = 4;
  localparam int DEF_ROW_BITS = 8;
  localparam int FID_W        = 4;

  typedef enum logic [2:0] {IDLE, WLOAD, WLATCH, STREAM, DRAIN, FIN} state_t;
endpackage

// File: rtl/pe_valid_pipe.sv
// Depth-N valid shift register; pend flags bits that will still be in flight next cycle.
module pe_valid_pipe #(
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  output logic [DEPTH-1:0] vld_pipe,
  output logic             pend
);
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[DEPTH-2:0], vld_in};
  end

  // The top stage leaves the pipe this cycle, so it does not count as pending.
  assign pend = |vld_pipe[DEPTH-2:0];
endmodule

// File: rtl/pe_array_ctrl.sv
// Layer-pass sequencer for the 3x8 PE array: filter load, row streaming, psum write tracking.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int MAX_ROWS = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ROW_BITS-1:0] cfg_rows,
  input  logic [FID_W-1:0]    cfg_filt_id,
  input  logic                hold,
  output logic                wt_rd_en,
  output logic [FID_W-1:0]    wt_rd_addr,
  output logic                filt_load,
  output logic                ifmap_rd_en,
  output logic [ROW_BITS-1:0] ifmap_rd_row,
  output logic                arr_valid,
  output logic                psum_wr_en,
  output logic [ROW_BITS-1:0] psum_wr_row,
  output logic                busy,
  output logic                done
);
  localparam int RW1 = ROW_BITS + 1;
  localparam logic [ROW_BITS-1:0] MAX_R = ROW_BITS'(MAX_ROWS);
  localparam logic [ROW_BITS-1:0] ONE   = ROW_BITS'(1);

  state_t              state;
  logic [ROW_BITS-1:0] rows, issue_cnt, wr_cnt, cap_rows;
  logic [PIPE_LAT:0]   vld_pipe;
  logic                pend;
  logic [RW1-1:0]      wr_next;

  // Row issue reacts to hold in the same cycle, so it is decoded rather than registered.
  assign ifmap_rd_en  = (state == STREAM) && !hold;
  assign ifmap_rd_row = issue_cnt;
  assign arr_valid    = vld_pipe[0];
  assign psum_wr_en   = vld_pipe[PIPE_LAT];
  assign psum_wr_row  = wr_cnt;
  assign wr_next      = {1'b0, wr_cnt} + RW1'(psum_wr_en);
  assign cap_rows     = (cfg_rows > MAX_R) ? MAX_R : cfg_rows;

  pe_valid_pipe #(.DEPTH(PIPE_LAT + 1)) u_vld (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (ifmap_rd_en),
    .vld_pipe (vld_pipe),
    .pend     (pend)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rows       <= '0;
      issue_cnt  <= '0;
      wr_cnt     <= '0;
      wt_rd_addr <= '0;
      wt_rd_en   <= 1'b0;
      filt_load  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wt_rd_en  <= 1'b0;
      filt_load <= 1'b0;
      done      <= 1'b0;
      if (psum_wr_en) wr_cnt <= wr_cnt + ONE;
      unique case (state)
        IDLE: if (start) begin
          rows       <= cap_rows;
          wt_rd_addr <= cfg_filt_id;
          wr_cnt     <= '0;
          wt_rd_en   <= 1'b1;
          busy       <= 1'b1;
          state      <= WLOAD;
        end
        WLOAD: begin
          filt_load <= 1'b1;
          state     <= WLATCH;
        end
        WLATCH: begin
          issue_cnt <= '0;
          if (rows == '0) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            state <= STREAM;
          end
        end
        STREAM: if (!hold) begin
          issue_cnt <= issue_cnt + ONE;
          if (issue_cnt == rows - ONE) state <= DRAIN;
        end
        // Look one cycle ahead so done lands right after the final write.
        DRAIN: if (!pend && wr_next == {1'b0, rows}) begin
          done  <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl: event timing and row order per pass.
module tb_pe_array_ctrl;
  localparam int PL = 4;

  logic       clk = 1'b0;
  logic       rst, start, hold;
  logic [7:0] cfg_rows;
  logic [3:0] cfg_filt_id;
  logic       wt_rd_en, filt_load, ifmap_rd_en, arr_valid, psum_wr_en, busy, done;
  logic [3:0] wt_rd_addr;
  logic [7:0] ifmap_rd_row, psum_wr_row;
  logic [26:0] outs;

  pe_array_ctrl #(.PIPE_LAT(PL), .ROW_BITS(8), .MAX_ROWS(255)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_filt_id(cfg_filt_id),
    .hold(hold), .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .filt_load(filt_load),
    .ifmap_rd_en(ifmap_rd_en), .ifmap_rd_row(ifmap_rd_row), .arr_valid(arr_valid),
    .psum_wr_en(psum_wr_en), .psum_wr_row(psum_wr_row), .busy(busy), .done(done)
  );

  assign outs = {wt_rd_en, wt_rd_addr, filt_load, ifmap_rd_en, ifmap_rd_row,
                 arr_valid, psum_wr_en, psum_wr_row, busy, done};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int t0 = 0, snap_k = -1, snap = -1, busy_n = 0, arr_n = 0;
  bit rec = 1'b0;
  int rd_t[$], rd_r[$], wr_t[$], wr_r[$], done_t[$], wt_t[$], wt_a[$], fl_t[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    #1;
    if (rec) begin
      int k;
      k = cyc - t0;
      if (wt_rd_en)    begin wt_t.push_back(k); wt_a.push_back(int'(wt_rd_addr)); end
      if (filt_load)   fl_t.push_back(k);
      if (ifmap_rd_en) begin rd_t.push_back(k); rd_r.push_back(int'(ifmap_rd_row)); end
      if (psum_wr_en)  begin wr_t.push_back(k); wr_r.push_back(int'(psum_wr_row)); end
      if (done)        done_t.push_back(k);
      if (busy)        busy_n++;
      if (arr_valid)   arr_n++;
      if (k == snap_k) snap = int'(outs);
    end
  end

  // Cycle 0 is the cycle start is high; hold/restart/reset are applied per relative cycle.
  task automatic run_pass(input int rows, input int fid, input int hs, input int hl,
                          input int rs_k, input int rst_k, input int ncyc);
    rd_t.delete(); rd_r.delete(); wr_t.delete(); wr_r.delete();
    done_t.delete(); wt_t.delete(); wt_a.delete(); fl_t.delete();
    busy_n = 0; arr_n = 0;
    @(negedge clk);
    cfg_rows = 8'(rows); cfg_filt_id = 4'(fid); start = 1'b1; hold = 1'b0;
    t0 = cyc; rec = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = (k == rs_k);
      if (k == rs_k) begin cfg_rows = 8'd9; cfg_filt_id = 4'd7; end
      hold = (k >= hs && k < hs + hl);
      rst  = (k == rst_k);
    end
    @(negedge clk);
    rec = 1'b0; hold = 1'b0; rst = 1'b0;
  endtask

  task automatic check_pass(input string tag, input int rows, input int fid,
                            input int hs, input int hl);
    int er[$];
    int k, exp_done;
    k = 3;
    for (int r = 0; r < rows; r++) begin
      while (k >= hs && k < hs + hl) k++;
      er.push_back(k);
      k++;
    end
    exp_done = (rows == 0) ? 3 : er[rows-1] + PL + 2;
    chk($sformatf("%s_nrd", tag), rd_t.size(), rows);
    chk($sformatf("%s_nwr", tag), wr_t.size(), rows);
    chk($sformatf("%s_narr", tag), arr_n, rows);
    for (int r = 0; r < rows; r++) begin
      if (r < rd_t.size()) begin
        chk($sformatf("%s_rd_t%0d", tag, r), rd_t[r], er[r]);
        chk($sformatf("%s_rd_r%0d", tag, r), rd_r[r], r);
      end
      if (r < wr_t.size()) begin
        chk($sformatf("%s_wr_t%0d", tag, r), wr_t[r], er[r] + 1 + PL);
        chk($sformatf("%s_wr_r%0d", tag, r), wr_r[r], r);
      end
    end
    chk($sformatf("%s_ndone", tag), done_t.size(), 1);
    if (done_t.size() > 0) chk($sformatf("%s_done_t", tag), done_t[0], exp_done);
    chk($sformatf("%s_nwt", tag), wt_t.size(), 1);
    if (wt_t.size() > 0) begin
      chk($sformatf("%s_wt_t", tag), wt_t[0], 1);
      chk($sformatf("%s_wt_a", tag), wt_a[0], fid);
    end
    chk($sformatf("%s_nfl", tag), fl_t.size(), 1);
    if (fl_t.size() > 0) chk($sformatf("%s_fl_t", tag), fl_t[0], 2);
    chk($sformatf("%s_busy_n", tag), busy_n, exp_done);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; cfg_rows = '0; cfg_filt_id = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", int'(outs), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    run_pass(8, 3, -1, 0, -1, -1, 30);
    check_pass("p8", 8, 3, -1, 0);
    chk("p8_first_wr", (wr_t.size() > 0) ? wr_t[0] : -1, 8);
    chk("p8_done16", (done_t.size() > 0) ? done_t[0] : -1, 16);

    // Hold for the two cycles after the second issue: reads 3,4,7,8,9.
    run_pass(5, 5, 5, 2, -1, -1, 30);
    check_pass("hold", 5, 5, 5, 2);

    run_pass(0, 9, -1, 0, -1, -1, 10);
    check_pass("zero", 0, 9, -1, 0);

    run_pass(6, 2, -1, 0, 5, -1, 30);
    check_pass("restart", 6, 2, -1, 0);

    // Reset at the end of cycle 13 (DRAIN, writes for rows 6,7 still in flight).
    snap_k = 14; snap = -1;
    run_pass(8, 1, -1, 0, -1, 13, 30);
    snap_k = -1;
    chk("rstmid_outs", snap, 0);
    chk("rstmid_ndone", done_t.size(), 0);
    chk("rstmid_nwr", wr_t.size(), 6);
    chk("rstmid_nrd", rd_t.size(), 8);
    chk("rstmid_busy_n", busy_n, 13);

    run_pass(3, 4, -1, 0, -1, -1, 20);
    check_pass("post_rst", 3, 4, -1, 0);

    run_pass(255, 15, -1, 0, -1, -1, 280);
    check_pass("max", 255, 15, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
